// File: rtl/instr_issue_queue.sv
// instr_issue_queue: instruction FIFO with NOP/illegal filtering, head decode and RAW-hazard issue stall
module instr_issue_queue #(
  parameter int DEPTH    = 4,
  parameter int SB_DEPTH = 3,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [0:31]   in_instr,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:31]   out_instr,
  output logic [0:4]    out_rd,
  output logic [0:4]    out_ra,
  output logic [0:4]    out_rb,
  output logic [0:1]    out_cls,
  output logic          stall_haz,
  output logic          illegal,
  output logic [0:CW-1] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [0:5] OP_NOP = 6'b000000;
  localparam logic [0:5] OP_LD  = 6'b000001;
  localparam logic [0:5] OP_ST  = 6'b000010;
  localparam logic [0:5] OP_ALU = 6'b000100;
  localparam logic [0:5] OP_VMV = 6'b001000;
  logic [0:31]         r_mem [DEPTH];
  logic [AW-1:0]       r_wp, r_rp;
  logic [CW-1:0]       r_cnt;
  logic [SB_DEPTH-1:0] r_sb_v;
  logic [4:0]          r_sb_rd [SB_DEPTH];
  logic                r_illegal;
  logic [0:5]          w_in_op, w_op;
  logic                w_in_legal, w_acc, w_push, w_pop, w_empty, w_haz;
  logic                w_is_alu, w_is_ld, w_is_st, w_is_vmv;
  assign w_in_op    = in_instr[0:5];
  assign w_in_legal = w_in_op inside {OP_LD, OP_ST, OP_ALU, OP_VMV};
  assign in_ready   = r_cnt != CW'(DEPTH);
  assign w_acc      = in_valid & in_ready;
  assign w_push     = w_acc & w_in_legal;
  assign w_empty    = r_cnt == '0;
  assign out_instr  = r_mem[r_rp];
  assign w_op       = out_instr[0:5];
  assign out_rd     = out_instr[6:10];
  assign out_ra     = out_instr[11:15];
  assign out_rb     = out_instr[16:20];
  assign w_is_alu   = w_op == OP_ALU;
  assign w_is_ld    = w_op == OP_LD;
  assign w_is_st    = w_op == OP_ST;
  assign w_is_vmv   = w_op == OP_VMV;
  assign out_cls    = {w_is_st | w_is_vmv, w_is_ld | w_is_vmv};
  assign out_valid  = ~w_empty & ~w_haz;
  assign stall_haz  = ~w_empty & w_haz;
  assign w_pop      = out_valid & out_ready;
  assign illegal    = r_illegal;
  assign count      = r_cnt;
  // head is blocked while any in-flight destination matches a register it reads
  always_comb begin
    w_haz = 1'b0;
    for (int k = 0; k < SB_DEPTH; k++)
      w_haz = w_haz | (r_sb_v[k] & (((w_is_alu | w_is_vmv) & (r_sb_rd[k] == out_ra)) |
                                    (w_is_alu & (r_sb_rd[k] == out_rb)) |
                                    (w_is_st & (r_sb_rd[k] == out_rd))));
  end
  // queue pointers, occupancy and the one-cycle illegal-drop pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_wp      <= r_wp + AW'(w_push);
      r_rp      <= r_rp + AW'(w_pop);
      r_cnt     <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_illegal <= w_acc & ~w_in_legal & (w_in_op != OP_NOP);
    end
  end
  // entry storage; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) if (w_push) r_mem[r_wp] <= in_instr;
  // writeback scoreboard: each issued destination ages one slot per cycle
  always_ff @(posedge clk) begin
    if (!rst) r_sb_v <= '0;
    else begin
      r_sb_v[0] <= w_pop & ~w_is_st;
      for (int k = 1; k < SB_DEPTH; k++) r_sb_v[k] <= r_sb_v[k-1];
    end
    r_sb_rd[0] <= out_rd;
    for (int k = 1; k < SB_DEPTH; k++) r_sb_rd[k] <= r_sb_rd[k-1];
  end
endmodule

// File: tb/tb_instr_issue_queue.sv
// tb_instr_issue_queue: directed and random checks against a queue/busy-until reference model
module tb_instr_issue_queue;
  localparam int DEPTH = 4, SB = 3, CW = 3;
  logic          clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [0:31]   in_instr = '0;
  logic          in_ready, out_valid, stall_haz, illegal;
  logic [0:31]   out_instr;
  logic [0:4]    out_rd, out_ra, out_rb;
  logic [0:1]    out_cls;
  logic [0:CW-1] count;
  int            n_assert = 0, n_fail = 0;
  logic [31:0]   q[$];
  int            busy [32];
  int            cyc = 0;
  logic          ill_exp = 1'b0;

  instr_issue_queue #(.DEPTH(DEPTH), .SB_DEPTH(SB), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_rd(out_rd),
    .out_ra(out_ra), .out_rb(out_rb), .out_cls(out_cls), .stall_haz(stall_haz),
    .illegal(illegal), .count(count));

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(logic [5:0] op, logic [4:0] rd, logic [4:0] ra, logic [4:0] rb);
    return {op, rd, ra, rb, 11'h0};
  endfunction

  // 0 ALU, 1 LD, 2 ST, 3 VMV, 4 NOP, 5 illegal
  function automatic int kind(logic [31:0] i);
    case (i[31:26])
      6'b000100: return 0;
      6'b000001: return 1;
      6'b000010: return 2;
      6'b001000: return 3;
      6'b000000: return 4;
      default:   return 5;
    endcase
  endfunction

  function automatic bit reads(logic [31:0] i, int r);
    int k = kind(i);
    return (k == 0 && (r == int'(i[20:16]) || r == int'(i[15:11]))) ||
           (k == 2 && r == int'(i[25:21])) || (k == 3 && r == int'(i[20:16]));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    q.delete();
    for (int r = 0; r < 32; r++) busy[r] = -100;
    ill_exp = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    clear_model();
    cyc++;
    #1 rst = 1'b1;
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic rdy);
    logic [31:0] h;
    bit haz, ev, er;
    in_valid = v; in_instr = ins; out_ready = rdy;
    @(negedge clk);
    haz = 0;
    h = '0;
    if (q.size() > 0) begin
      h = q[0];
      for (int r = 0; r < 32; r++) if (reads(h, r) && busy[r] >= cyc) haz = 1;
    end
    ev = q.size() > 0 && !haz;
    er = q.size() != DEPTH;
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("stall_haz", 32'(stall_haz), 32'(q.size() > 0 && haz));
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("count", 32'(count), 32'(q.size()));
    chk("illegal", 32'(illegal), 32'(ill_exp));
    if (q.size() > 0) begin
      chk("out_instr", out_instr, h);
      chk("out_rd", 32'(out_rd), 32'(h[25:21]));
      chk("out_ra", 32'(out_ra), 32'(h[20:16]));
      chk("out_rb", 32'(out_rb), 32'(h[15:11]));
      chk("out_cls", 32'(out_cls), 32'(kind(h)));
    end
    @(posedge clk);
    if (ev && rdy) begin
      if (kind(h) inside {0, 1, 3}) busy[h[25:21]] = cyc + SB;
      void'(q.pop_front());
    end
    ill_exp = v && er && kind(ins) == 5;
    if (v && er && kind(ins) < 4) q.push_back(ins);
    cyc++;
    #1;
  endtask

  logic [5:0] ops [4] = '{6'b000100, 6'b000001, 6'b000010, 6'b001000};

  initial begin
    clear_model();
    #1;
    do_reset();
    step(0, 0, 0);
    // reset mid-fill must leave no queued entries or scoreboard residue
    for (int i = 0; i < 3; i++) step(1, mk(6'b000100, 5'(i + 1), 5'd20, 5'd21), 1'b0);
    step(1, mk(6'b000100, 5'd7, 5'd20, 5'd21), 1'b1);
    do_reset();
    step(0, 0, 0);
    step(1, mk(6'b000100, 5'd9, 5'd7, 5'd1), 1'b1);
    step(0, 0, 1);
    step(0, 0, 1);
    // fill to DEPTH with the fifth push refused, then drain in order
    for (int i = 0; i < 5; i++) step(1, 32'h11AA5800, 1'b0);
    step(0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    // NOP and illegal opcodes are accepted but never stored
    step(1, 32'h01AA5D8B, 1'b0);
    step(1, 32'hFC000000, 1'b0);
    step(0, 0, 0);
    step(0, 0, 0);
    // RAW on r13 stalls the reader for SB cycles
    step(1, mk(6'b000100, 5'd13, 5'd1, 5'd2), 1'b1);
    step(1, mk(6'b000100, 5'd14, 5'd13, 5'd3), 1'b1);
    for (int i = 0; i < 6; i++) step(0, 0, 1);
    // loads only write, so back-to-back LD r13 never stalls
    step(1, mk(6'b000001, 5'd13, 5'd0, 5'd0), 1'b1);
    step(1, mk(6'b000001, 5'd13, 5'd0, 5'd0), 1'b1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    // wrap with simultaneous push and pop at count 2
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    step(1, mk(6'b000100, 5'd31, 5'd20, 5'd21), 1'b0);
    step(1, mk(6'b000100, 5'd31, 5'd22, 5'd23), 1'b0);
    for (int i = 0; i < 10; i++) step(1, mk(6'b000100, 5'd31, 5'(i), 5'(i + 1)), 1'b1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    // random traffic over a small register set so hazards are frequent
    for (int i = 0; i < 500; i++) begin
      int k;
      logic [5:0] op;
      if ($urandom_range(0, 99) == 0) do_reset();
      k = $urandom_range(0, 5);
      op = (k < 4) ? ops[k] : (k == 4 ? 6'b000000 : 6'($urandom));
      step(1'($urandom_range(0, 2) != 0),
           mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))),
           1'($urandom_range(0, 3) != 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
